// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_CMP = 2'b00,
    OP_MUL = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, the first one folded into load.
module mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;

  // Low half starts as the multiplier and drains one bit per step while the product fills from the top.
  function automatic logic [2*WIDTH-1:0] shift_add(input logic [WIDTH-1:0]   m,
                                                   input logic [2*WIDTH-1:0] acc);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
      cnt     <= '0;
    end else if (load) begin
      mcand   <= a;
      product <= shift_add(a, {{WIDTH{1'b0}}, b});
      cnt     <= CNT_ONE;
    end else if (step) begin
      product <= shift_add(mcand, product);
      cnt     <= cnt + CNT_ONE;
    end
  end

  assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle compare/add/subtract, multi-cycle multiply, registered results.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_hi,
  output logic             cout,
  output logic             ready,
  output logic             done
);

  import alu_pkg::*;

  state_t             state;
  state_t             state_nxt;
  logic               load;
  logic               step;
  logic               last;
  logic               accept;
  logic [2*WIDTH-1:0] product;

  // Returns {flag, result} for the single-cycle operations.
  function automatic logic [WIDTH:0] alu_op(input logic [1:0]       o,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             c);
    logic [WIDTH:0] ci;
    ci = {{WIDTH{1'b0}}, c};
    case (o)
      OP_CMP:  alu_op = {(a <= b), {WIDTH{1'b0}}};
      OP_ADD:  alu_op = {1'b0, a} + {1'b0, b} + ci;
      OP_SUB:  alu_op = {1'b0, a} + {1'b0, ~b} + ci;
      default: alu_op = '0;
    endcase
  endfunction

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .a      (x),
    .b      (y),
    .product(product),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = (op == OP_MUL);
          state_nxt = (op == OP_MUL) ? MUL : DONE;
        end
      end
      MUL:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && start;
  assign step   = (state == MUL) && !last;
  assign ready  = (state == IDLE);
  assign done   = (state == DONE);

  // Results only move on the edge that enters DONE, so they hold through MUL and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      f    <= '0;
      f_hi <= '0;
      cout <= 1'b0;
    end else if (accept && (op != OP_MUL)) begin
      {cout, f} <= alu_op(op, x, y, cin);
      f_hi      <= '0;
    end else if ((state == MUL) && last) begin
      f    <= product[WIDTH-1:0];
      f_hi <= product[2*WIDTH-1:WIDTH];
      cout <= |product[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8) using an expected-result queue.
module tb_seq_alu;

  localparam int W = 8;
  localparam logic [1:0] CMP = 2'b00;
  localparam logic [1:0] MUL = 2'b01;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] SUB = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic [W-1:0] f;
  logic [W-1:0] f_hi;
  logic         cout;
  logic         ready;
  logic         done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] f_hi;
    logic       cout;
    logic [7:0] lat;
  } exp_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] ef;
    logic [7:0] eh;
    logic       ec;
  } vec_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .x    (x),
    .y    (y),
    .cin  (cin),
    .f    (f),
    .f_hi (f_hi),
    .cout (cout),
    .ready(ready),
    .done (done)
  );

  // Independent reference used for randomised operands.
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input logic c);
    exp_t e;
    int   s;
    e     = '0;
    e.lat = (o == MUL) ? 8'd9 : 8'd1;
    case (o)
      CMP: e.cout = (int'(a) <= int'(b));
      MUL: begin
        s = int'(a) * int'(b);
        e.f = s[7:0]; e.f_hi = s[15:8]; e.cout = (s > 255);
      end
      ADD: begin
        s = int'(a) + int'(b) + int'(c);
        e.f = s[7:0]; e.cout = (s > 255);
      end
      default: begin
        s = int'(a) + (255 - int'(b)) + int'(c);
        e.f = s[7:0]; e.cout = (s > 255);
      end
    endcase
    return e;
  endfunction

  // Drives one operation, pushes its expectation, then waits (bounded) for done.
  // Operands are scrambled right after the accepting edge; outputs are watched for early change.
  task automatic run_op(input vec_t v, output int lat, output bit stable, output bit rdy);
    logic [7:0] pf, ph;
    logic       pc;
    exp_q.push_back({v.ef, v.eh, v.ec, (v.op == MUL) ? 8'd9 : 8'd1});
    @(negedge clk);
    rdy = ready;
    start = 1'b1; op = v.op; x = v.a; y = v.b; cin = v.c;
    @(posedge clk);
    #1;
    start = 1'b0; op = v.op ^ 2'b11; x = ~v.a; y = v.b + 8'd37; cin = ~v.c;
    pf = f; ph = f_hi; pc = cout;
    stable = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if ({f, f_hi, cout} !== {pf, ph, pc}) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = ADD; x = 8'd1; y = 8'd1; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ready, done} !== 2'b10) begin
      bad++; $display("FAIL reset_ctrl: ready,done got %b want 10", {ready, done});
    end
    total++;
    if ({f_hi, f, cout} !== 17'd0) begin
      bad++; $display("FAIL reset_outs: f_hi=%0d f=%0d cout=%b want all 0", f_hi, f, cout);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if ({ready, done} !== 2'b10) begin
      bad++; $display("FAIL reset_prio: ready,done got %b want 10", {ready, done});
    end
  endtask

  task automatic test_compare();
    vec_t t[4];
    int lat; bit st, rdy; exp_t e;
    t = '{'{CMP, 8'd5,   8'd5,   1'b0, 8'd0, 8'd0, 1'b1},
          '{CMP, 8'd6,   8'd5,   1'b0, 8'd0, 8'd0, 1'b0},
          '{CMP, 8'd0,   8'd255, 1'b1, 8'd0, 8'd0, 1'b1},
          '{CMP, 8'd255, 8'd0,   1'b1, 8'd0, 8'd0, 1'b0}};
    foreach (t[i]) begin
      run_op(t[i], lat, st, rdy);
      e = exp_q.pop_front();
      total++;
      if ({f_hi, f, cout} !== {e.f_hi, e.f, e.cout}) begin
        bad++; $display("FAIL cmp[%0d]: got f_hi=%0d f=%0d cout=%b want %0d %0d %b", i, f_hi, f, cout, e.f_hi, e.f, e.cout);
      end
      total++;
      if (lat !== int'(e.lat)) begin
        bad++; $display("FAIL cmp_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_add();
    vec_t t[5];
    int lat; bit st, rdy; exp_t e;
    t = '{'{ADD, 8'd200, 8'd100, 1'b0, 8'd44,  8'd0, 1'b1},
          '{ADD, 8'd255, 8'd1,   1'b0, 8'd0,   8'd0, 1'b1},
          '{ADD, 8'd255, 8'd0,   1'b1, 8'd0,   8'd0, 1'b1},
          '{ADD, 8'd254, 8'd0,   1'b1, 8'd255, 8'd0, 1'b0},
          '{ADD, 8'd0,   8'd0,   1'b0, 8'd0,   8'd0, 1'b0}};
    foreach (t[i]) begin
      run_op(t[i], lat, st, rdy);
      e = exp_q.pop_front();
      total++;
      if ({f_hi, f, cout} !== {e.f_hi, e.f, e.cout}) begin
        bad++; $display("FAIL add[%0d]: got f_hi=%0d f=%0d cout=%b want %0d %0d %b", i, f_hi, f, cout, e.f_hi, e.f, e.cout);
      end
      total++;
      if (lat !== int'(e.lat)) begin
        bad++; $display("FAIL add_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_sub();
    vec_t t[6];
    int lat; bit st, rdy; exp_t e;
    t = '{'{SUB, 8'd3,   8'd5,   1'b1, 8'd254, 8'd0, 1'b0},
          '{SUB, 8'd5,   8'd3,   1'b1, 8'd2,   8'd0, 1'b1},
          '{SUB, 8'd0,   8'd0,   1'b1, 8'd0,   8'd0, 1'b1},
          '{SUB, 8'd0,   8'd0,   1'b0, 8'd255, 8'd0, 1'b0},
          '{SUB, 8'd255, 8'd255, 1'b1, 8'd0,   8'd0, 1'b1},
          '{SUB, 8'd0,   8'd255, 1'b1, 8'd1,   8'd0, 1'b0}};
    foreach (t[i]) begin
      run_op(t[i], lat, st, rdy);
      e = exp_q.pop_front();
      total++;
      if ({f_hi, f, cout} !== {e.f_hi, e.f, e.cout}) begin
        bad++; $display("FAIL sub[%0d]: got f_hi=%0d f=%0d cout=%b want %0d %0d %b", i, f_hi, f, cout, e.f_hi, e.f, e.cout);
      end
      total++;
      if (lat !== int'(e.lat)) begin
        bad++; $display("FAIL sub_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t t[6];
    int lat; bit st, rdy; exp_t e;
    t = '{'{MUL, 8'd255, 8'd255, 1'b0, 8'h01, 8'hFE, 1'b1},
          '{MUL, 8'd0,   8'd200, 1'b1, 8'd0,  8'd0,  1'b0},
          '{MUL, 8'd200, 8'd0,   1'b0, 8'd0,  8'd0,  1'b0},
          '{MUL, 8'd16,  8'd16,  1'b0, 8'd0,  8'd1,  1'b1},
          '{MUL, 8'd1,   8'd255, 1'b0, 8'd255, 8'd0, 1'b0},
          '{MUL, 8'd12,  8'd10,  1'b0, 8'd120, 8'd0, 1'b0}};
    foreach (t[i]) begin
      run_op(t[i], lat, st, rdy);
      e = exp_q.pop_front();
      total++;
      if ({f_hi, f, cout} !== {e.f_hi, e.f, e.cout}) begin
        bad++; $display("FAIL mul[%0d]: got f_hi=%0d f=%0d cout=%b want %0d %0d %b", i, f_hi, f, cout, e.f_hi, e.f, e.cout);
      end
      total++;
      if (lat !== int'(e.lat)) begin
        bad++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      end
      total++;
      if (st !== 1'b1) begin
        bad++; $display("FAIL mul_hold[%0d]: outputs changed before done (stable=%b want 1)", i, st);
      end
    end
  endtask

  task automatic test_busy();
    exp_t e;
    int dones = 0, at = -1;
    bit rlow = 1'b1;
    logic [7:0] rf = '0, rh = '0;
    logic rc = 1'b0;
    exp_q.push_back({8'd143, 8'd0, 1'b0, 8'd9});
    @(negedge clk);
    start = 1'b1; op = MUL; x = 8'd13; y = 8'd11; cin = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (done) begin
        dones++; at = i; rf = f; rh = f_hi; rc = cout;
      end
      if (i <= 9 && ready) rlow = 1'b0;
      start = (i <= 9);
      op = 2'($urandom_range(3, 0));
      x  = 8'($urandom_range(255, 1));
      y  = 8'($urandom_range(255, 1));
    end
    start = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL busy_count: got %0d done pulses want 1", dones);
    end
    total++;
    if (at !== int'(e.lat)) begin
      bad++; $display("FAIL busy_lat: got %0d want %0d", at, e.lat);
    end
    total++;
    if ({rh, rf, rc} !== {e.f_hi, e.f, e.cout}) begin
      bad++; $display("FAIL busy_result: got f_hi=%0d f=%0d cout=%b want %0d %0d %b", rh, rf, rc, e.f_hi, e.f, e.cout);
    end
    total++;
    if (rlow !== 1'b1) begin
      bad++; $display("FAIL busy_ready: ready rose while busy (flag=%b want 1)", rlow);
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[4];
    int lat; bit st, rdy; exp_t e;
    t = '{'{SUB, 8'd10, 8'd3, 1'b1, 8'd7,  8'd0, 1'b1},
          '{ADD, 8'd1,  8'd2, 1'b0, 8'd3,  8'd0, 1'b0},
          '{MUL, 8'd3,  8'd5, 1'b0, 8'd15, 8'd0, 1'b0},
          '{CMP, 8'd7,  8'd7, 1'b0, 8'd0,  8'd0, 1'b1}};
    foreach (t[i]) begin
      run_op(t[i], lat, st, rdy);
      e = exp_q.pop_front();
      total++;
      if ({f_hi, f, cout, lat} !== {e.f_hi, e.f, e.cout, int'(e.lat)}) begin
        bad++; $display("FAIL b2b[%0d]: got f_hi=%0d f=%0d cout=%b lat=%0d want %0d %0d %b %0d", i, f_hi, f, cout, lat, e.f_hi, e.f, e.cout, e.lat);
      end
      total++;
      if (rdy !== 1'b1) begin
        bad++; $display("FAIL b2b_ready[%0d]: ready at issue got %b want 1", i, rdy);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    vec_t v;
    int lat, dones;
    bit st, rdy;
    exp_t e;
    v = '{ADD, 8'd200, 8'd100, 1'b0, 8'd44, 8'd0, 1'b1};
    run_op(v, lat, st, rdy);
    e = exp_q.pop_front();
    total++;
    if ({f_hi, f, cout} !== {e.f_hi, e.f, e.cout}) begin
      bad++; $display("FAIL abort_pre: got f=%0d cout=%b want %0d %b", f, cout, e.f, e.cout);
    end
    @(negedge clk);
    start = 1'b1; op = MUL; x = 8'd255; y = 8'd255; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({done, ready, f_hi, f, cout} !== {1'b0, 1'b1, 17'd0}) begin
      bad++; $display("FAIL abort_state: done=%b ready=%b f_hi=%0d f=%0d cout=%b want 0 1 0 0 0", done, ready, f_hi, f, cout);
    end
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL abort_done: got %0d done pulses want 0", dones);
    end
    v = '{ADD, 8'd3, 8'd4, 1'b1, 8'd8, 8'd0, 1'b0};
    run_op(v, lat, st, rdy);
    e = exp_q.pop_front();
    total++;
    if ({f_hi, f, cout, lat} !== {e.f_hi, e.f, e.cout, int'(e.lat)}) begin
      bad++; $display("FAIL abort_post: got f=%0d cout=%b lat=%0d want %0d %b %0d", f, cout, lat, e.f, e.cout, e.lat);
    end
  endtask

  task automatic test_random();
    vec_t v;
    exp_t m, e;
    int lat; bit st, rdy;
    for (int n = 0; n < 24; n++) begin
      v.op = 2'($urandom_range(3, 0));
      v.a  = 8'($urandom_range(255, 0));
      v.b  = 8'($urandom_range(255, 0));
      v.c  = 1'($urandom_range(1, 0));
      m = model(v.op, v.a, v.b, v.c);
      v.ef = m.f; v.eh = m.f_hi; v.ec = m.cout;
      run_op(v, lat, st, rdy);
      e = exp_q.pop_front();
      total++;
      if ({f_hi, f, cout, lat} !== {e.f_hi, e.f, e.cout, int'(e.lat)}) begin
        bad++; $display("FAIL rand[%0d] op=%0d a=%0d b=%0d c=%b: got f_hi=%0d f=%0d cout=%b lat=%0d want %0d %0d %b %0d",
                        n, v.op, v.a, v.b, v.c, f_hi, f, cout, lat, e.f_hi, e.f, e.cout, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_add();
    test_sub();
    test_mul();
    test_busy();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, setting the operand width; legal range is 2..32.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port start  input  1  SHALL request an operation; it is accepted only when ready=1.
REQ-005 Port op  input  2  SHALL select the operation: 00 compare, 01 multiply, 10 add, 11 subtract.
REQ-006 Port x  input  WIDTH  SHALL carry operand A, unsigned.
REQ-007 Port y  input  WIDTH  SHALL carry operand B, unsigned.
REQ-008 Port cin  input  1  SHALL carry the carry-in for add and subtract.
REQ-009 Port f  output  WIDTH  SHALL carry the result, or the low half of the product.
REQ-010 Port f_hi  output  WIDTH  SHALL carry the high half of the product, and 0 for all other ops.
REQ-011 Port cout  output  1  SHALL carry the flag: compare result, carry, no-borrow, or multiply overflow.
REQ-012 Port ready  output  1  SHALL be high only in state IDLE.
REQ-013 Port done  output  1  SHALL be a one-cycle pulse marking valid f, f_hi and cout.

Function
REQ-014 The FSM SHALL have the states IDLE, MUL and DONE.
REQ-015 The FSM SHALL take these transitions:
- IDLE->DONE when start and op≠01;
- IDLE->MUL when start and op=01;
- MUL->DONE after WIDTH iterations;
- DONE->IDLE unconditionally.
REQ-016 x, y, op and cin SHALL be captured on the accepting edge; later changes to them SHALL NOT affect the result.
REQ-017 Compare SHALL set cout=(x<=y) unsigned, f=0 and f_hi=0.
REQ-018 Add SHALL set {cout,f}=x+y+cin as a (WIDTH+1)-bit sum, with f_hi=0.
REQ-019 Subtract SHALL set {cout,f}=x+~y+cin, with f_hi=0; with cin=1 this is x-y and cout=1 means no borrow.
REQ-020 Multiply SHALL use iterative shift-add, one partial product per cycle, and produce {f_hi,f}=x*y exact to 2*WIDTH bits, with cout=|f_hi.
REQ-021 Latency SHALL be measured from the accepting edge to the first cycle with done=1: 1 cycle for compare/add/subtract, WIDTH+1 cycles for multiply.
REQ-022 done SHALL be high for exactly one cycle, in state DONE.
REQ-023 f, f_hi and cout SHALL be registered and SHALL hold their value from the DONE cycle until the next DONE cycle.
REQ-024 start while ready=0 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-025 start during DONE SHALL be ignored; the earliest acceptance after DONE is the following IDLE cycle.
REQ-026 f, f_hi and cout SHALL NOT change during MUL until the DONE cycle.
REQ-027 Multiply SHALL be exact for x=0, y=0 and x=y=2^WIDTH-1.
REQ-028 Carry and borrow SHALL be correct at all wrap-around boundaries, e.g. all-ones plus 1.

Reset
REQ-029 On a clock edge with rst=1, the state SHALL become IDLE and f, f_hi, cout and done SHALL become 0; ready SHALL be 1 in the following cycle.
REQ-030 rst SHALL take priority over start on the same edge; the start is not accepted.
REQ-031 rst during MUL SHALL abort the operation with no done pulse, and the iteration counter and partial product SHALL be cleared.
REQ-032 Before the first reset, output values SHALL be unspecified.

Structure
REQ-033 Package alu_pkg SHALL hold the op encodings (OP_CMP, OP_MUL, OP_ADD, OP_SUB) and the state type (IDLE, MUL, DONE).
REQ-034 The multiply datapath SHALL be a single sub-module, mul_iter, parameterised by WIDTH, with ports load, step, product and last.
REQ-035 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=8)
REQ-036 Compare: x=5, y=5, start -> one cycle later done=1, cout=1, f=0; then x=6, y=5 -> cout=0.
REQ-037 Add: x=200, y=100, cin=0 -> f=44, cout=1, f_hi=0, done one cycle after accept.
REQ-038 Subtract: x=3, y=5, cin=1 -> f=254, cout=0; then x=5, y=3, cin=1 -> f=2, cout=1.
REQ-039 Multiply: x=255, y=255 -> done exactly 9 cycles after accept, f_hi=0xFE, f=0x01, cout=1; then x=12, y=10 -> f=120, f_hi=0, cout=0.
REQ-040 Busy: start asserted every cycle during a multiply with different operands -> exactly one done, with the first product.
REQ-041 Reset mid-multiply: rst asserted at iteration 4 -> no done, outputs 0, ready=1 next cycle, and the next add is correct.
